// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl
//   Time-multiplexed scan controller for a common-segment 7-segment display.
//   The shared 2-bit decoder (A, B) is driven with the selected digit's code.
//   Each digit slot is a blank gap (all anodes off) followed by a show window.
//   New display data arrives over a valid/ready port. It is held in a pending
//   buffer and takes effect only at a frame boundary, so a frame never tears.
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   enable        1 = scanning, 0 = dark (idle)
//   load_valid/load_ready/load_data   display load handshake, 2 bits per digit
//   digit_A/B     decoder inputs for the addressed digit
//   anode_n       active-low digit enables, at most one bit low
//   digit_idx     digit currently addressed
//   slot_tick     pulse on the last show cycle of every slot
module segment_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [2*NUM_DIGITS-1:0]       load_data,
  output logic                          digit_A,
  output logic                          digit_B,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          slot_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [2*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [2*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    full_q, full_d;
  logic                    a_q, a_d;
  logic                    b_q, b_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    tick_q, tick_d;
  logic                    accept;
  logic [1:0]              sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      anode_q <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      a_q     <= a_d;
      b_q     <= b_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    full_d  = full_q;
    a_d     = a_q;
    b_d     = b_q;
    anode_d = '1;
    tick_d  = 1'b0;
    accept  = load_valid && !full_q;

    // The slot counter runs across the whole slot: blank for the first
    // BLANK_CYCLES counts, show for the rest, and it is cleared on slot entry.
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              // Frame boundary: the next frame starts with the pending data.
              if (full_q) begin
                disp_d = pend_q;
                full_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Only reachable with the buffer empty, so it never collides with the
    // boundary transfer above.
    if (accept) begin
      pend_d = load_data;
      full_d = 1'b1;
    end

    // Outputs are computed from the next state and registered. The decoder
    // code is loaded on entry to BLANK so it settles before the anode turns on.
    sel = 2'(disp_d >> {idx_d, 1'b0});
    if (state_d == ST_BLANK && state_q != ST_BLANK) begin
      a_d = sel[1];
      b_d = sel[0];
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = !(state_d == ST_SHOW && idx_d == IW'(i));
    end
    tick_d = (state_d == ST_SHOW) && (cnt_d == SLOT_LAST);
  end

  assign load_ready = !full_q;
  assign digit_A    = a_q;
  assign digit_B    = b_q;
  assign anode_n    = anode_q;
  assign digit_idx  = idx_q;
  assign slot_tick  = tick_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Testbench for segment_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// A run-time model (cycles since scanning started -> slot, digit, offset)
// predicts every output on each falling edge. Directed steps add literal
// expectations at the cycles of interest.
module tb_segment_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         load_valid;
  logic         load_ready;
  logic [7:0]   load_data;
  logic         digit_A;
  logic         digit_B;
  logic [3:0]   anode_n;
  logic [1:0]   digit_idx;
  logic         slot_tick;

  int checks = 0;
  int errors = 0;

  segment_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .digit_A   (digit_A),
    .digit_B   (digit_B),
    .anode_n   (anode_n),
    .digit_idx (digit_idx),
    .slot_tick (slot_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: run = cycles since scanning started (-1 when dark).
  int         run;
  logic [7:0] m_disp;
  logic [7:0] m_pend;
  logic       m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run    = -1;
      m_disp = '0;
      m_pend = '0;
      m_full = 1'b0;
    end else begin
      automatic logic acc = load_valid && !m_full;
      if (!enable) begin
        run = -1;
      end else begin
        if (run >= 0 && (run % RD) == RD - 1 && ((run / RD) % N) == N - 1 && m_full) begin
          m_disp = m_pend;
          m_full = 1'b0;
        end
        run = run + 1;
      end
      if (acc) begin
        m_pend = load_data;
        m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic int         off = (run >= 0) ? run % RD : 0;
      automatic int         d   = (run >= 0) ? (run / RD) % N : 0;
      automatic logic [3:0] ea  = 4'b1111;
      automatic logic [7:0] sh  = m_disp >> (2 * d);
      if (run >= 0 && off >= BC) ea = ~(4'b0001 << d);
      chk("m_anode", anode_n, ea);
      chk("m_idx", digit_idx, d);
      chk("m_tick", slot_tick, run >= 0 && off == RD - 1);
      chk("m_ready", load_ready, !m_full);
      if (run >= 0) begin
        chk("m_A", digit_A, sh[1]);
        chk("m_B", digit_B, sh[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!load_ready && n < 200) begin
      cyc(1);
      n++;
    end
    chk(nm, n < 200, 1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    #1;
    chk("rst_anode", anode_n, 4'b1111);
    chk("rst_A", digit_A, 0);
    chk("rst_B", digit_B, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_tick", slot_tick, 0);
    chk("rst_ready", load_ready, 1);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Scan from a zero display.
    enable = 1'b1;
    cyc(1);  chk("c1_anode", anode_n, 4'b1111);
    cyc(2);  chk("c3_anode", anode_n, 4'b1110);
    cyc(5);  chk("c8_tick", slot_tick, 1);
    cyc(1);  chk("c9_anode", anode_n, 4'b1111);
             chk("c9_tick", slot_tick, 0);
    cyc(2);  chk("c11_anode", anode_n, 4'b1101);
             chk("c11_idx", digit_idx, 1);

    // Load during digit 1; applied at the c32 frame boundary.
    load_valid = 1'b1;
    load_data  = 8'b11_10_01_00;
    cyc(1);  load_valid = 1'b0;
             chk("c12_ready", load_ready, 0);
    cyc(20); chk("c32_tick", slot_tick, 1);
             chk("c32_idx", digit_idx, 3);
             chk("c32_ready", load_ready, 0);
             chk("c32_A", digit_A, 0);
    cyc(1);  chk("c33_ready", load_ready, 1);
    cyc(2);  chk("c35_AB", {digit_A, digit_B}, 2'b00);
    cyc(8);  chk("c43_AB", {digit_A, digit_B}, 2'b01);
    cyc(8);  chk("c51_AB", {digit_A, digit_B}, 2'b10);
    cyc(8);  chk("c59_AB", {digit_A, digit_B}, 2'b11);
             chk("c59_anode", anode_n, 4'b0111);

    // Back-to-back loads: the second is held off until the boundary.
    load_valid = 1'b1;
    load_data  = 8'hAA;
    cyc(1);
    load_data  = 8'h55;
    chk("b2b_ready0", load_ready, 0);
    wait_ready("b2b_wait1");
    chk("aa_AB", {digit_A, digit_B}, 2'b10);
    cyc(1);
    load_valid = 1'b0;
    chk("b2b_ready1", load_ready, 0);
    wait_ready("b2b_wait2");
    chk("55_AB", {digit_A, digit_B}, 2'b01);
    cyc(40);

    // Disable during digit 2 show, then resume.
    n = 0;
    while (!(digit_idx == 2 && anode_n == 4'b1011) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("d2_wait", n < 100, 1);
    enable = 1'b0;
    cyc(1);  chk("dis_anode", anode_n, 4'b1111);
             chk("dis_idx", digit_idx, 0);
    cyc(3);
    enable = 1'b1;
    cyc(1);  chk("re_c1_anode", anode_n, 4'b1111);
    cyc(2);  chk("re_c3_anode", anode_n, 4'b1110);
             chk("re_c3_idx", digit_idx, 0);

    // Asynchronous reset mid-run, checked before any clock edge.
    cyc(5);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_anode", anode_n, 4'b1111);
    chk("arst_AB", {digit_A, digit_B}, 2'b00);
    chk("arst_idx", digit_idx, 0);
    chk("arst_ready", load_ready, 1);
    chk("arst_tick", slot_tick, 0);
    enable = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Load accepted in the boundary cycle: shown one frame later.
    enable = 1'b1;
    cyc(32); chk("bd_tick", slot_tick, 1);
             chk("bd_idx", digit_idx, 3);
             chk("bd_ready", load_ready, 1);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    cyc(1);  load_valid = 1'b0;
             chk("bd_ready0", load_ready, 0);
    cyc(2);  chk("bd_c35_AB", {digit_A, digit_B}, 2'b00);
    cyc(32); chk("bd_c67_AB", {digit_A, digit_B}, 2'b11);
             chk("bd_c67_ready", load_ready, 1);
    cyc(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
